// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM states, flag bit positions.
// Op codes are 5 bits wide so the extended multiply (OP_MUL) shares the encoding space
// with the 4-bit FunSel op field; FunSel ops map to {1'b0, op}.
package alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned KIND_W = 5;
    localparam int unsigned FUN_W  = 5;

    // FunSel bit selecting full (1) or half (0) width
    localparam int unsigned FUN_FULL = 4;

    localparam logic [KIND_W-1:0] OP_MOVA = 5'd0;
    localparam logic [KIND_W-1:0] OP_MOVB = 5'd1;
    localparam logic [KIND_W-1:0] OP_NOTA = 5'd2;
    localparam logic [KIND_W-1:0] OP_NOTB = 5'd3;
    localparam logic [KIND_W-1:0] OP_ADD  = 5'd4;
    localparam logic [KIND_W-1:0] OP_ADC  = 5'd5;
    localparam logic [KIND_W-1:0] OP_SUB  = 5'd6;
    localparam logic [KIND_W-1:0] OP_AND  = 5'd7;
    localparam logic [KIND_W-1:0] OP_OR   = 5'd8;
    localparam logic [KIND_W-1:0] OP_XOR  = 5'd9;
    localparam logic [KIND_W-1:0] OP_NAND = 5'd10;
    localparam logic [KIND_W-1:0] OP_LSL  = 5'd11;
    localparam logic [KIND_W-1:0] OP_LSR  = 5'd12;
    localparam logic [KIND_W-1:0] OP_ASR  = 5'd13;
    localparam logic [KIND_W-1:0] OP_CSL  = 5'd14;
    localparam logic [KIND_W-1:0] OP_CSR  = 5'd15;
    localparam logic [KIND_W-1:0] OP_MUL  = 5'd16;

    // Bit positions inside the {Z,C,N,V} flag vector
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_MUL,
        S_DONE
    } state_t;

    // Shift and rotate ops run iteratively, one bit per cycle
    function automatic logic is_shift_op(input logic [KIND_W-1:0] kind);
        return (kind >= OP_LSL) && (kind <= OP_CSR);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational Z/C/N/V generation for every ALU op.
// Ports:
//   result  : sign-extended result (only the active width matters)
//   a_msb   : operand A sign bit of the active width
//   b_msb   : operand B sign bit of the active width
//   kind    : 5-bit op kind (FunSel op, or OP_MUL)
//   full    : 1 = full width, 0 = half width
//   aux_c   : carry for shifts/rotates (last bit out) and multiply (high half nonzero)
//   flags_c : {Z,C,N,V}
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]  result,
    input  logic              a_msb,
    input  logic              b_msb,
    input  logic [KIND_W-1:0] kind,
    input  logic              full,
    input  logic              aux_c,
    output logic [3:0]        flags_c
);

    localparam int unsigned H = WIDTH / 2;

    logic r_msb;

    always_comb begin
        flags_c = '0;
        r_msb   = full ? result[WIDTH-1] : result[H-1];

        flags_c[FLAG_Z] = full ? (result == '0) : (result[H-1:0] == '0);
        flags_c[FLAG_N] = r_msb;

        // Carry/borrow out of the top bit is recovered from the top-bit
        // operands and result: the carry into that bit is a^b^r.
        case (kind)
            OP_ADD, OP_ADC: begin
                flags_c[FLAG_C] = (a_msb & b_msb) | ((a_msb ^ b_msb) & ~r_msb);
                flags_c[FLAG_V] = (a_msb == b_msb) && (r_msb != a_msb);
            end
            OP_SUB: begin
                flags_c[FLAG_C] = (~a_msb & b_msb) | (~(a_msb ^ b_msb) & r_msb);
                flags_c[FLAG_V] = (a_msb != b_msb) && (r_msb != a_msb);
            end
            OP_LSL, OP_LSR, OP_ASR, OP_CSL, OP_CSR, OP_MUL: begin
                flags_c[FLAG_C] = aux_c;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/iterative_alu.sv
// Handshaked, parametrised ALU with iterative shifts/rotates and registered result.
// Optional macro ITERATIVE_ALU_MUL_EN adds an unsigned shift-add multiply on Ext=1.
// Ports:
//   Clock, Reset       : rising-edge clock, synchronous active-high reset
//   InValid / InReady  : request handshake (InReady high only when idle)
//   A, B               : operands (B[SHW-1:0] is also the shift amount)
//   FunSel             : [4] full/half width, [3:0] op
//   Ext                : extended op (multiply)
//   WF                 : flag write enable, captured at accept
//   OutValid / OutReady: result handshake
//   ALUOut, FlagsOut   : registered result and {Z,C,N,V}
module iterative_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [FUN_W-1:0] FunSel,
    input  logic             Ext,
    input  logic             WF,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);

    localparam int unsigned H     = WIDTH / 2;
    localparam int unsigned CNT_W = SHW + 1;
    localparam logic [WIDTH-1:0] HALF_MASK = {{(WIDTH-H){1'b0}}, {H{1'b1}}};

    // Sign-extend from the active width's top bit
    function automatic logic [WIDTH-1:0] fit(input logic [WIDTH-1:0] v, input logic full);
        return full ? v : {{(WIDTH-H){v[H-1]}}, v[H-1:0]};
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sc_q, sc_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              full_q, full_d;
    logic              wf_q, wf_d;
    logic [WIDTH-1:0]  alu_out_q, alu_out_d;
    logic [3:0]        flags_q, flags_d;
    logic              in_ready_q, out_valid_q;

`ifdef ITERATIVE_ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] mul_acc_nx;
    logic               mul_hi_nz;
`endif

    // Request-side operand shaping and single-cycle result
    logic              in_full;
    logic [KIND_W-1:0] in_kind;
    logic [WIDTH-1:0]  a_act, b_act, raw;
    logic [SHW-1:0]    k_full, shift_amt;

    always_comb begin
        in_full   = FunSel[FUN_FULL];
        in_kind   = {1'b0, FunSel[OP_W-1:0]};
        a_act     = in_full ? A : (A & HALF_MASK);
        b_act     = in_full ? B : (B & HALF_MASK);
        k_full    = B[SHW-1:0];
        shift_amt = in_full ? k_full : SHW'(32'(k_full) % H);

        case (in_kind)
            OP_MOVA: raw = a_act;
            OP_MOVB: raw = b_act;
            OP_NOTA: raw = ~a_act;
            OP_NOTB: raw = ~b_act;
            OP_ADD:  raw = a_act + b_act;
            OP_ADC:  raw = a_act + b_act + WIDTH'(flags_q[FLAG_C]);
            OP_SUB:  raw = a_act - b_act;
            OP_AND:  raw = a_act & b_act;
            OP_OR:   raw = a_act | b_act;
            OP_XOR:  raw = a_act ^ b_act;
            OP_NAND: raw = ~(a_act & b_act);
            default: raw = a_act;  // zero-amount shift passes A through
        endcase
    end

    // One shift/rotate step on the work register; half mode keeps upper bits zero
    logic             w_msb, fill, step_left, step_c;
    logic [WIDTH-1:0] step_w;

    always_comb begin
        w_msb     = full_q ? work_q[WIDTH-1] : work_q[H-1];
        step_left = ({1'b0, op_q} == OP_LSL) || ({1'b0, op_q} == OP_CSL);

        case ({1'b0, op_q})
            OP_ASR:         fill = w_msb;
            OP_CSL, OP_CSR: fill = sc_q;
            default:        fill = 1'b0;
        endcase

        if (step_left) begin
            step_w = {work_q[WIDTH-2:0], fill};
            if (!full_q) begin
                step_w = step_w & HALF_MASK;
            end
            step_c = w_msb;
        end else begin
            step_w = {1'b0, work_q[WIDTH-1:1]};
            if (full_q) begin
                step_w[WIDTH-1] = fill;
            end else begin
                step_w[H-1] = fill;
            end
            step_c = work_q[0];
        end
    end

`ifdef ITERATIVE_ALU_MUL_EN
    // Shift-add step: multiplier LSB in work_q, multiplicand shifts left
    always_comb begin
        mul_acc_nx = work_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_hi_nz  = full_q ? (|mul_acc_nx[2*WIDTH-1:WIDTH]) : (|mul_acc_nx[WIDTH-1:H]);
    end
`endif

    // Flag generator shared by single-cycle, shift and multiply completion
    logic [WIDTH-1:0]  fg_result;
    logic              fg_a_msb, fg_b_msb, fg_full, fg_aux_c;
    logic [KIND_W-1:0] fg_kind;
    logic [3:0]        fg_flags_c;

    always_comb begin
        fg_result = fit(raw, in_full);
        fg_a_msb  = in_full ? a_act[WIDTH-1] : a_act[H-1];
        fg_b_msb  = in_full ? b_act[WIDTH-1] : b_act[H-1];
        fg_kind   = in_kind;
        fg_full   = in_full;
        fg_aux_c  = flags_q[FLAG_C];

        case (state_q)
            S_SHIFT: begin
                fg_result = fit(step_w, full_q);
                fg_a_msb  = 1'b0;
                fg_b_msb  = 1'b0;
                fg_kind   = {1'b0, op_q};
                fg_full   = full_q;
                fg_aux_c  = step_c;
            end
`ifdef ITERATIVE_ALU_MUL_EN
            S_MUL: begin
                fg_result = fit(mul_acc_nx[WIDTH-1:0], full_q);
                fg_a_msb  = 1'b0;
                fg_b_msb  = 1'b0;
                fg_kind   = OP_MUL;
                fg_full   = full_q;
                fg_aux_c  = mul_hi_nz;
            end
`endif
            default: begin
            end
        endcase
    end

    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .result  (fg_result),
        .a_msb   (fg_a_msb),
        .b_msb   (fg_b_msb),
        .kind    (fg_kind),
        .full    (fg_full),
        .aux_c   (fg_aux_c),
        .flags_c (fg_flags_c)
    );

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        sc_d      = sc_q;
        op_d      = op_q;
        full_d    = full_q;
        wf_d      = wf_q;
        alu_out_d = alu_out_q;
        flags_d   = flags_q;
`ifdef ITERATIVE_ALU_MUL_EN
        acc_d     = acc_q;
        mcand_d   = mcand_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (InValid) begin
                    op_d   = FunSel[OP_W-1:0];
                    full_d = in_full;
                    wf_d   = WF;
                    sc_d   = flags_q[FLAG_C];
                    work_d = a_act;
                    if (Ext) begin
`ifdef ITERATIVE_ALU_MUL_EN
                        work_d  = b_act;
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, a_act};
                        cnt_d   = in_full ? CNT_W'(WIDTH) : CNT_W'(H);
                        state_d = S_MUL;
`else
                        alu_out_d = '0;
                        state_d   = S_DONE;
`endif
                    end else if (is_shift_op(in_kind) && (shift_amt != '0)) begin
                        cnt_d   = CNT_W'(shift_amt);
                        state_d = S_SHIFT;
                    end else begin
                        alu_out_d = fg_result;
                        if (WF) begin
                            flags_d = fg_flags_c;
                        end
                        state_d = S_DONE;
                    end
                end
            end

            S_SHIFT: begin
                work_d = step_w;
                sc_d   = step_c;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    alu_out_d = fg_result;
                    if (wf_q) begin
                        flags_d = fg_flags_c;
                    end
                    state_d = S_DONE;
                end
            end

            S_MUL: begin
`ifdef ITERATIVE_ALU_MUL_EN
                acc_d   = mul_acc_nx;
                mcand_d = mcand_q << 1;
                work_d  = work_q >> 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    alu_out_d = fg_result;
                    if (wf_q) begin
                        flags_d = fg_flags_c;
                    end
                    state_d = S_DONE;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_DONE: begin
                if (OutReady) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            sc_q        <= 1'b0;
            op_q        <= '0;
            full_q      <= 1'b0;
            wf_q        <= 1'b0;
            alu_out_q   <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ITERATIVE_ALU_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            sc_q        <= sc_d;
            op_q        <= op_d;
            full_q      <= full_d;
            wf_q        <= wf_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
`ifdef ITERATIVE_ALU_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
`endif
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign ALUOut   = alu_out_q;
    assign FlagsOut = flags_q;

endmodule

// File: doc/iterative_alu.md
Name: iterative_alu

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- Adds generic WIDTH with a half-width mode, shifts/rotates by a variable amount (B) run iteratively one bit per cycle, and a registered result held under valid/ready flow control.
- Flags Z|C|N|V are computed correctly for every op, including proper subtract overflow.
- Sits between the register-file read ports and the write-back mux; the control FSM drives InValid and consumes OutValid.

Parameters:
- WIDTH, 32, full datapath width; even, >= 8. H = WIDTH/2 is the half width.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0].

Ports:
- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- InValid  in  1  operation request.
- InReady  out  1  high only in IDLE; transfer when InValid&&InReady.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; also the shift amount for shift/rotate ops.
- FunSel  in  5  [4]=1 full width / 0 half width (low H bits, result sign-extended); [3:0]=op.
- Ext  in  1  extended-op select (multiply, see Optional Feature).
- WF  in  1  flag write enable, latched at accept.
- OutValid  out  1  result available.
- OutReady  in  1  consumer accepts the result.
- ALUOut  out  WIDTH  registered result.
- FlagsOut  out  4  {Z,C,N,V}, registered.

Behaviour:
- Reset:
  - state=IDLE; ALUOut=0; FlagsOut=0; OutValid=0; InReady=1.
  - Reset mid-operation aborts the op with no flag update.
- Op codes [3:0]:
  - 0 A, 1 B, 2 ~A, 3 ~B
  - 4 A+B, 5 A+B+C, 6 A-B
  - 7 AND, 8 OR, 9 XOR, 10 NAND
  - 11 LSL, 12 LSR, 13 ASR, 14 rotate-left through C, 15 rotate-right through C
- Operands and results:
  - Half mode operates on the low H bits of the operands.
  - Result is sign-extended from bit H-1 to WIDTH.
  - Active width n = WIDTH (full) or H (half).
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: on accept, latch A, B, FunSel, Ext, WF and a snapshot of C.
    - Ops 0-10: compute, go to DONE. Latency 1: OutValid is high the cycle after accept.
    - Ops 11-15 with amount k=B[SHW-1:0]; half mode uses k mod H.
      - k=0: DONE directly; result=A, C unchanged.
      - Otherwise SHIFT with counter=k; one bit per cycle; DONE when counter reaches 0. Latency 1+k.
    - Ext=1: see Optional Feature.
  - DONE: OutValid=1; ALUOut and FlagsOut stable.
    - If OutReady is high, go to IDLE the same edge.
    - OutReady low holds all outputs indefinitely.
    - InReady=0 in DONE (no same-cycle back-to-back); throughput is one op per latency+1 cycles.
- Flags are written on the edge entering DONE, only if the latched WF=1; otherwise FlagsOut holds.
  - Z = active-width result == 0.
  - N = result[n-1].
  - C:
    - add/addc: carry out of bit n-1.
    - sub: borrow (A <u B, active width).
    - shifts/rotates: last bit shifted out.
    - logic/move: 0.
  - V:
    - add: A[n-1]==B[n-1] && R[n-1]!=A[n-1].
    - sub: A[n-1]!=B[n-1] && R[n-1]!=A[n-1].
    - all others: 0.
- Addc uses the C snapshot taken at accept. Rotates feed the snapshot C in and recirculate it each step.
- InValid while not in IDLE is ignored (not accepted).

Optional Feature:
- Macro: ITERATIVE_ALU_MUL_EN.
- Defined: Ext=1 selects unsigned shift-add multiply of the active-width operands.
  - Enters MUL; takes n cycles; latency 1+n.
  - ALUOut = low n bits of the product (sign-extended in half mode).
  - C = upper n product bits nonzero; V=0; Z/N from the result.
- Undefined: Ext=1 is accepted and goes straight to DONE with ALUOut=0, FlagsOut untouched, no MUL logic synthesised.

Decomposition:
- Package alu_pkg:
  - op code localparams (OP_MOVA..OP_CSR, OP_MUL)
  - state enum (S_IDLE, S_SHIFT, S_MUL, S_DONE)
  - flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0)
- One sub-module, alu_flag_gen: combinational Z/C/N/V from result, operands, op and width mode. Reused by the FSM for single-cycle, shift and multiply completion.

Test Plan:
- Full add, WIDTH=32, A=0x7FFFFFFF, B=1, WF=1 -> one cycle later OutValid=1, ALUOut=0x80000000, FlagsOut=0b0011 (N,V).
- Half sub, A=0x0000_0003, B=0x0000_0005 -> ALUOut=0xFFFFFFFE; C=1, N=1, V=0, Z=0.
- Full LSL, A=0x80000001, B=4 -> OutValid 5 cycles after accept, ALUOut=0x00000010, C=0. Also B=0 -> ALUOut=A, C unchanged.
- Backpressure: OutReady=0 for 10 cycles after DONE -> ALUOut/FlagsOut stable, InReady=0, new InValid ignored.
- Reset asserted on cycle 3 of a k=8 shift -> next cycle IDLE, OutValid=0, FlagsOut=0. Also WF=0 op -> FlagsOut unchanged.
- MUL_EN defined: A=0x10000, B=0x10000, full mode -> latency 33, ALUOut=0, C=1, Z=1. Undefined: ALUOut=0, flags unchanged.
